// File: rtl/regfile_pkg.sv
// Shared constants, width helper and word typedefs for the multi-ported register file.
package regfile_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;

  // Ceiling log2, never less than 1 so that a bus width is always legal.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  localparam int AW_DEF = clog2(NREG_DEF);
  localparam int CW_DEF = clog2(NREG_DEF + 1);

  typedef logic [AW_DEF-1:0]   reg_addr_t;
  typedef logic [XLEN_DEF-1:0] reg_data_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-producer scoreboard: one busy bit per register plus a registered popcount.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int AW   = clog2(NREG),
  parameter int CW   = clog2(NREG + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_rd,
  input  logic            flush,
  input  logic [NREG-1:0] wr_mask,
  output logic [NREG-1:0] busy,
  output logic [CW-1:0]   busy_cnt
);

  logic [NREG-1:0] busy_d, busy_q, set_mask;
  logic [CW-1:0]   busy_cnt_d, busy_cnt_q;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
    set_mask   = '0;
    busy_cnt_d = '0;
    if (iss_valid && (iss_rd != '0)) set_mask[iss_rd] = 1'b1;
    // Set is OR-ed after the clear so a new producer wins over a retiring one.
    busy_d = flush ? '0 : ((busy_q & ~wr_mask) | set_mask);
    for (int r = 0; r < NREG; r++) begin
      busy_cnt_d = busy_cnt_d + CW'(busy_d[r]);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values together.
    if (!rst_n) begin
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign busy     = busy_q;
  assign busy_cnt = busy_cnt_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-ported register file with zero-latency write bypass and a pending-producer scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int NRD  = 4,
  parameter int NWR  = 2,
  parameter int AW   = clog2(NREG),
  parameter int CW   = clog2(NREG + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NWR-1:0]      we,
  input  logic [NWR*AW-1:0]   waddr,
  input  logic [NWR*XLEN-1:0] wdata,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*XLEN-1:0] rdata,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_rd,
  input  logic                flush,
  output logic [NRD-1:0]      rbusy,
  output logic [CW-1:0]       busy_cnt
);

  logic [XLEN-1:0] mem_d [NREG];
  logic [XLEN-1:0] mem_q [NREG];
  logic [NREG-1:0] wr_mask;
  logic [NREG-1:0] busy;
  logic [AW-1:0]   rd_addr [NRD];
  logic [XLEN-1:0] rd_word [NRD];
  logic [NRD-1:0]  rd_hit;

  // Writes to x0 are dropped here, so x0 storage never leaves zero.
  always_comb begin
    mem_d   = mem_q;
    wr_mask = '0;
    for (int j = 0; j < NWR; j++) begin
      if (we[j] && (waddr[j*AW +: AW] != '0)) begin
        mem_d[waddr[j*AW +: AW]] = wdata[j*XLEN +: XLEN];
        wr_mask[waddr[j*AW +: AW]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the storage array is reset explicitly because reads after reset must return zero, not leftover data.
      for (int r = 0; r < NREG; r++) mem_q[r] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  // Ascending port scan lets the highest-indexed same-cycle writer win the bypass.
  always_comb begin
    rdata = '0;
    rbusy = '0;
    for (int i = 0; i < NRD; i++) begin
      rd_addr[i] = raddr[i*AW +: AW];
      rd_word[i] = mem_q[rd_addr[i]];
      rd_hit[i]  = 1'b0;
      for (int j = 0; j < NWR; j++) begin
        if (we[j] && (waddr[j*AW +: AW] == rd_addr[i])) begin
          rd_word[i] = wdata[j*XLEN +: XLEN];
          rd_hit[i]  = 1'b1;
        end
      end
      if (rd_addr[i] != '0) begin
        rdata[i*XLEN +: XLEN] = rd_word[i];
        rbusy[i] = busy[rd_addr[i]] && !rd_hit[i];
      end
    end
  end

  regfile_scoreboard #(
    .NREG (NREG),
    .AW   (AW),
    .CW   (CW)
  ) u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .flush     (flush),
    .wr_mask   (wr_mask),
    .busy      (busy),
    .busy_cnt  (busy_cnt)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: directed scenarios with literal expectations, then random traffic against an array model.
module tb_regfile_mp;
  import regfile_pkg::*;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 4;
  localparam int NWR  = 2;
  localparam int AW   = 5;
  localparam int CW   = 6;

  logic                clk;
  logic                rst_n;
  logic [NWR-1:0]      we;
  logic [NWR*AW-1:0]   waddr;
  logic [NWR*XLEN-1:0] wdata;
  logic [NRD*AW-1:0]   raddr;
  logic [NRD*XLEN-1:0] rdata;
  logic                iss_valid;
  logic [AW-1:0]       iss_rd;
  logic                flush;
  logic [NRD-1:0]      rbusy;
  logic [CW-1:0]       busy_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 0;

  // Reference model: plain arrays updated by the architectural rules.
  logic [XLEN-1:0] m_mem  [NREG];
  bit              m_busy [NREG];

  regfile_mp #(
    .XLEN (XLEN),
    .NREG (NREG),
    .NRD  (NRD),
    .NWR  (NWR)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .raddr     (raddr),
    .rdata     (rdata),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .flush     (flush),
    .rbusy     (rbusy),
    .busy_cnt  (busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] exp_rdata(input int i);
    logic [AW-1:0]   a;
    logic [XLEN-1:0] v;
    a = raddr[i*AW +: AW];
    if (a == '0) return '0;
    v = m_mem[a];
    for (int j = 0; j < NWR; j++)
      if (we[j] && waddr[j*AW +: AW] == a) v = wdata[j*XLEN +: XLEN];
    return v;
  endfunction

  function automatic bit exp_rbusy(input int i);
    logic [AW-1:0] a;
    a = raddr[i*AW +: AW];
    if (a == '0) return 1'b0;
    for (int j = 0; j < NWR; j++)
      if (we[j] && waddr[j*AW +: AW] == a) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic int exp_cnt();
    int c = 0;
    for (int r = 0; r < NREG; r++) c += int'(m_busy[r]);
    return c;
  endfunction

  initial begin
    for (int r = 0; r < NREG; r++) begin
      m_mem[r]  = '0;
      m_busy[r] = 1'b0;
    end
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) begin
        m_mem[r]  = '0;
        m_busy[r] = 1'b0;
      end
    end else begin
      for (int j = 0; j < NWR; j++)
        if (we[j] && waddr[j*AW +: AW] != '0) m_mem[waddr[j*AW +: AW]] = wdata[j*XLEN +: XLEN];
      if (flush) begin
        for (int r = 0; r < NREG; r++) m_busy[r] = 1'b0;
      end else begin
        for (int j = 0; j < NWR; j++)
          if (we[j]) m_busy[waddr[j*AW +: AW]] = 1'b0;
        if (iss_valid && iss_rd != '0) m_busy[iss_rd] = 1'b1;
      end
    end
  end

  // Compare process: every cycle, away from the rising edge.
  always @(negedge clk) begin
    if (check_en && rst_n) begin
      for (int i = 0; i < NRD; i++) begin
        check($sformatf("model_rdata%0d", i), 64'(rdata[i*XLEN +: XLEN]), 64'(exp_rdata(i)));
        check($sformatf("model_rbusy%0d", i), 64'(rbusy[i]), 64'(exp_rbusy(i)));
      end
      check("model_busy_cnt", 64'(busy_cnt), 64'(exp_cnt()));
    end
  end

  task automatic idle();
    we        = '0;
    waddr     = '0;
    wdata     = '0;
    iss_valid = 1'b0;
    iss_rd    = '0;
    flush     = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int port, input int addr, input logic [XLEN-1:0] data);
    we[port] = 1'b1;
    waddr[port*AW +: AW] = AW'(addr);
    wdata[port*XLEN +: XLEN] = data;
  endtask

  task automatic issue(input int addr);
    iss_valid = 1'b1;
    iss_rd    = AW'(addr);
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    if ($urandom_range(0, 1) == 0) return AW'($urandom_range(0, 7));
    return AW'($urandom_range(0, NREG - 1));
  endfunction

  initial begin
    idle();
    raddr = '0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n    = 1'b1;
    check_en = 1'b1;

    // Reset state on four ports.
    raddr = {5'd31, 5'd5, 5'd1, 5'd0};
    @(negedge clk);
    for (int i = 0; i < NRD; i++) check($sformatf("rst_rdata%0d", i), 64'(rdata[i*XLEN +: XLEN]), 64'h0);
    check("rst_rbusy", 64'(rbusy), 64'h0);
    check("rst_busy_cnt", 64'(busy_cnt), 64'h0);
    tick();

    // Same-address dual write: port 1 wins, bypass and storage.
    raddr = '0;
    raddr[0 +: AW] = 5'd5;
    wr(0, 5, 32'hAAAA0000);
    wr(1, 5, 32'h5555FFFF);
    @(negedge clk);
    check("dual_wr_bypass", 64'(rdata[0 +: XLEN]), 64'h5555FFFF);
    tick();
    idle();
    @(negedge clk);
    check("dual_wr_storage", 64'(rdata[0 +: XLEN]), 64'h5555FFFF);
    tick();

    // Issue x7, observe busy, retire with a bypassed write.
    issue(7);
    tick();
    idle();
    raddr[0 +: AW] = 5'd7;
    @(negedge clk);
    check("x7_rbusy", 64'(rbusy[0]), 64'h1);
    check("x7_busy_cnt", 64'(busy_cnt), 64'h1);
    tick();
    wr(0, 7, 32'h12345678);
    @(negedge clk);
    check("x7_bypass", 64'(rdata[0 +: XLEN]), 64'h12345678);
    check("x7_rbusy_bypass", 64'(rbusy[0]), 64'h0);
    tick();
    idle();
    @(negedge clk);
    check("x7_cnt_cleared", 64'(busy_cnt), 64'h0);
    tick();

    // Coincident set and clear on x9: set wins.
    issue(9);
    wr(1, 9, 32'hCAFEF00D);
    tick();
    idle();
    raddr[0 +: AW] = 5'd9;
    @(negedge clk);
    check("x9_rbusy", 64'(rbusy[0]), 64'h1);
    check("x9_busy_cnt", 64'(busy_cnt), 64'h1);
    check("x9_data", 64'(rdata[0 +: XLEN]), 64'hCAFEF00D);
    tick();

    // x0 write is ignored, bypass included.
    raddr = '0;
    wr(0, 0, 32'hFFFFFFFF);
    @(negedge clk);
    check("x0_bypass", 64'(rdata[0 +: XLEN]), 64'h0);
    tick();
    idle();
    @(negedge clk);
    check("x0_storage", 64'(rdata[0 +: XLEN]), 64'h0);
    check("x0_rbusy", 64'(rbusy[0]), 64'h0);

    // Three issues, then flush dominating a same-cycle issue.
    issue(3);
    tick();
    issue(4);
    tick();
    issue(6);
    tick();
    idle();
    @(negedge clk);
    check("pre_flush_cnt", 64'(busy_cnt), 64'h4);
    flush = 1'b1;
    issue(8);
    tick();
    idle();
    raddr = {5'd8, 5'd6, 5'd4, 5'd3};
    @(negedge clk);
    check("flush_cnt", 64'(busy_cnt), 64'h0);
    check("flush_rbusy", 64'(rbusy), 64'h0);
    tick();

    // Mid-operation reset discards state and same-cycle activity.
    issue(2);
    tick();
    idle();
    wr(0, 2, 32'h0000DEAD);
    issue(11);
    tick();
    idle();
    rst_n = 1'b0;
    wr(1, 2, 32'h0000BEEF);
    issue(5);
    tick();
    idle();
    rst_n = 1'b1;
    raddr = {5'd5, 5'd11, 5'd0, 5'd2};
    @(negedge clk);
    check("rst_mid_x2", 64'(rdata[0 +: XLEN]), 64'h0);
    check("rst_mid_rbusy", 64'(rbusy), 64'h0);
    check("rst_mid_cnt", 64'(busy_cnt), 64'h0);
    tick();

    // Random traffic checked by the compare process.
    for (int c = 0; c < 1500; c++) begin
      rst_n     = ($urandom_range(0, 99) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      iss_valid = ($urandom_range(0, 2) == 0);
      iss_rd    = rnd_addr();
      for (int j = 0; j < NWR; j++) begin
        we[j] = ($urandom_range(0, 1) == 0);
        waddr[j*AW +: AW] = rnd_addr();
        wdata[j*XLEN +: XLEN] = $urandom();
      end
      for (int i = 0; i < NRD; i++) raddr[i*AW +: AW] = rnd_addr();
      tick();
    end

    idle();
    rst_n = 1'b1;
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter XLEN, default 32, register width in bits.
REQ-002 Parameter NREG, default 32, register count; power of two, at least 2; AW = clog2(NREG).
REQ-003 Parameter NRD, default 4, number of read ports.
REQ-004 Parameter NWR, default 2, number of write ports.
REQ-005 clk  in  1  the single clock; all state updates on the rising edge.
REQ-006 rst_n  in  1  reset, synchronous and active-low.
REQ-007 we  in  NWR  per-port write enable.
REQ-008 waddr  in  NWR*AW  per-port write address, port j in bits [j*AW +: AW].
REQ-009 wdata  in  NWR*XLEN  per-port write data.
REQ-010 raddr  in  NRD*AW  per-port read address.
REQ-011 rdata  out  NRD*XLEN  per-port read data.
REQ-012 iss_valid  in  1  issue strobe; marks iss_rd as having a pending producer.
REQ-013 iss_rd  in  AW  issued destination register.
REQ-014 flush  in  1  clears all pending-producer marks.
REQ-015 rbusy  out  NRD  per-read-port "operand not yet available" flag.
REQ-016 busy_cnt  out  clog2(NREG+1)  number of registers currently marked busy.

Function
REQ-017 Register 0 SHALL read as 0 on every port, ignore all writes, and never be marked busy.
REQ-018 A write on port j with we[j]=1 and waddr[j]!=0 SHALL update storage at the next rising edge.
REQ-019 If two or more ports write the same address in the same cycle, the highest-indexed port SHALL win.
REQ-020 Reads SHALL be combinational. If a same-cycle write targets raddr[i]!=0, rdata[i] SHALL equal that wdata (highest-indexed writer wins); otherwise rdata[i] SHALL equal storage. Bypass latency is 0 cycles.
REQ-021 The busy bit of register r SHALL be set at the edge when iss_valid=1 and iss_rd=r!=0.
REQ-022 The busy bit of register r SHALL be cleared at the edge when any port writes r.
REQ-023 If a set and a clear of the same register coincide, set SHALL win, because a new producer has issued.
REQ-024 flush=1 SHALL clear every busy bit at the edge. Flush SHALL dominate a same-cycle iss_valid, which is ignored.
REQ-025 rbusy[i] SHALL equal busy[raddr[i]] AND NOT (same-cycle write to raddr[i]). rbusy[i] SHALL be 0 when raddr[i]=0.
REQ-026 busy_cnt SHALL be a registered population count of the busy bits as they stand after each edge, and SHALL be exact when a set and a clear occur in the same cycle.

Reset
REQ-027 While rst_n=0 at an edge, all storage SHALL be set to 0, all busy bits to 0 and busy_cnt to 0; writes, issue and flush in that cycle SHALL be ignored.
REQ-028 After reset, every rdata SHALL be 0 and every rbusy SHALL be 0 until the first write or issue.
REQ-029 Reset asserted mid-operation SHALL discard in-flight writes and pending marks without residue.

Structure
REQ-030 Package regfile_pkg SHALL hold the default XLEN and NREG constants, the AW/count-width helper function, and typedefs for address and data words.
REQ-031 Busy-bit and counter logic SHALL live in one sub-module, regfile_scoreboard. Storage and the bypass muxes SHALL remain in regfile_mp.

Verification
REQ-032 Reset, then read all 4 ports at addresses 0,1,5,31 -> rdata all 0, rbusy all 0, busy_cnt=0.
REQ-033 Port 0 writes x5=0xAAAA0000 while port 1 writes x5=0x5555FFFF in the same cycle, with raddr0=5 -> rdata0=0x5555FFFF in that cycle and in storage from the next cycle.
REQ-034 Issue x7; next cycle raddr0=7 -> rbusy0=1 and busy_cnt=1; then write x7=0x12345678 -> in that cycle rdata0=0x12345678 and rbusy0=0; next cycle busy_cnt=0.
REQ-035 Issue x9 in the same cycle as a write to x9 -> x9 stays busy and busy_cnt=1; write x0=0xFFFFFFFF -> raddr=0 still reads 0.
REQ-036 Issue x3, x4 and x6, then flush together with issue of x8 -> all busy bits 0 and busy_cnt=0.
REQ-037 Issue x2 and write x2=0xDEAD, then pull rst_n low for one edge -> x2 reads 0, rbusy 0, busy_cnt=0.
